// File: rtl/mio_pkg.sv
// Shared types and address map for the memory/I-O bus controller.
package mio_pkg;

  localparam logic [31:0] LED_ADDR = 32'hE000_0000;
  localparam logic [31:0] SW_ADDR  = 32'hE000_0004;
  localparam logic [31:0] TMR_CNT  = 32'hF000_0000;
  localparam logic [31:0] TMR_CMP  = 32'hF000_0004;
  localparam logic [31:0] TMR_CLR  = 32'hF000_0008;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  typedef enum logic [1:0] {T_RAM, T_GPIO, T_TMR, T_ERR} target_e;

  // Map a byte address to its target; the two low address bits never matter.
  function automatic target_e decode(input logic [31:0] addr, input int unsigned ram_aw);
    logic [31:0] word;
    target_e     tgt;
    word = {addr[31:2], 2'b00};
    if ((word >> (ram_aw + 2)) == 32'd0) begin
      tgt = T_RAM;
    end else if (word == LED_ADDR || word == SW_ADDR) begin
      tgt = T_GPIO;
    end else if (word == TMR_CNT || word == TMR_CMP || word == TMR_CLR) begin
      tgt = T_TMR;
    end else begin
      tgt = T_ERR;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/mio_timer.sv
// Free-running 32-bit timer with a compare register and a sticky match interrupt.
module mio_timer
  import mio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_we,
  input  logic        cmp_we,
  input  logic        irq_clr,
  input  logic [31:0] wdata,
  input  logic [1:0]  rsel,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] cnt_q;
  logic [31:0] cmp_q;
  logic        irq_q;

  // Count every cycle unless a count write lands; a match wins over a clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 32'd0;
      cmp_q <= 32'hFFFF_FFFF;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_we ? wdata : cnt_q + 32'd1;
      if (cmp_we) begin
        cmp_q <= wdata;
      end
      if (cnt_q == cmp_q) begin
        irq_q <= 1'b1;
      end else if (irq_clr) begin
        irq_q <= 1'b0;
      end
    end
  end

  // Register read mux indexed by word offset; the clear register reads zero.
  always_comb begin
    rdata = 32'd0;
    unique case (rsel)
      2'd0:    rdata = cnt_q;
      2'd1:    rdata = cmp_q;
      default: rdata = 32'd0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: rtl/mio_bus_ctrl.sv
// Bus controller between the CPU memory port and the RAM, GPIO and timer targets.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW      = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned LED_W       = 8,
  parameter int unsigned SW_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   sw,
  output logic              irq,
  output logic              bus_err
);

  state_e           state_q, state_d;
  target_e          tgt_q;
  logic [31:0]      addr_q, wdata_q, rdata_q, rd_mux, tmr_rdata;
  logic             we_q, ready_q, ram_we_q, bus_err_q;
  logic [4:0]       wait_q;
  logic [LED_W-1:0] led_q;
  logic             accept, last, io_wr, is_ram;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^addr[1:0];

  assign accept = (state_q == IDLE) && cpu_req;
  // wait_q counts the ACCESS cycles still to go after the current one.
  assign last   = (state_q == ACCESS) && (wait_q == 5'd0);
  assign io_wr  = last && we_q;
  assign is_ram = (decode(addr, RAM_AW) == T_RAM);

  // Next-state logic for the IDLE -> ACCESS -> DONE handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cpu_req) state_d = ACCESS;
      ACCESS:  if (wait_q == 5'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data selected by the latched target, sampled at the final ACCESS edge.
  always_comb begin
    rd_mux = 32'd0;
    unique case (tgt_q)
      T_RAM:   rd_mux = ram_dout;
      T_GPIO:  rd_mux = addr_q[2] ? 32'(sw) : 32'(led_q);
      T_TMR:   rd_mux = tmr_rdata;
      default: rd_mux = 32'd0;
    endcase
  end

  // Request latch, wait-state counter, completion pulse and read-data register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tgt_q     <= T_RAM;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      wait_q    <= 5'd0;
      ram_we_q  <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ram_we_q <= 1'b0;
      ready_q  <= 1'b0;
      if (accept) begin
        addr_q   <= {addr[31:2], 2'b00};
        wdata_q  <= wdata;
        we_q     <= mem_w;
        tgt_q    <= decode(addr, RAM_AW);
        // RAM needs one extra cycle for the synchronous read port.
        wait_q   <= is_ram ? 5'(WAIT_STATES + 1) : 5'd0;
        ram_we_q <= mem_w && is_ram;
      end else if (state_q == ACCESS && wait_q != 5'd0) begin
        wait_q <= wait_q - 5'd1;
      end
      if (last) begin
        ready_q <= 1'b1;
        if (tgt_q == T_ERR) begin
          rdata_q   <= 32'd0;
          bus_err_q <= 1'b1;
        end else if (!we_q) begin
          rdata_q <= rd_mux;
        end
      end
    end
  end

  // LED register, written when a GPIO write completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q <= '0;
    end else if (io_wr && tgt_q == T_GPIO && addr_q == LED_ADDR) begin
      led_q <= wdata_q[LED_W-1:0];
    end
  end

  mio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .cnt_we  (io_wr && tgt_q == T_TMR && addr_q == TMR_CNT),
    .cmp_we  (io_wr && tgt_q == T_TMR && addr_q == TMR_CMP),
    .irq_clr (io_wr && tgt_q == T_TMR && addr_q == TMR_CLR),
    .wdata   (wdata_q),
    .rsel    (addr_q[3:2]),
    .rdata   (tmr_rdata),
    .irq     (irq)
  );

  assign rdata     = rdata_q;
  assign mio_ready = ready_q;
  assign ram_addr  = addr_q[RAM_AW+1:2];
  assign ram_we    = ram_we_q;
  assign ram_din   = wdata_q;
  assign led       = led_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Scoreboard bench: two controllers (0 and 3 wait states) share one stimulus stream.
module tb_mio_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [15:0] sw = 16'd0;

  logic [31:0] rdata0, rdata3, ram_din0, ram_din3, ram_dout0, ram_dout3;
  logic        ready0, ready3, ram_we0, ram_we3, irq0, irq3, berr0, berr3;
  logic [9:0]  ram_addr0, ram_addr3;
  logic [7:0]  led0, led3;
  logic [31:0] mem0 [1024];
  logic [31:0] mem3 [1024];

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    int          cyc;
    logic [9:0]  raddr;
  } exp_t;

  exp_t        q0[$];
  exp_t        q3[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          we_cnt0 = 0;
  int          we_cnt3 = 0;
  int          wr_acc = 0;
  logic [9:0]  we_addr0, we_addr3;

  mio_bus_ctrl #(.RAM_AW(10), .WAIT_STATES(0), .LED_W(8), .SW_W(16)) dut0 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .mem_w(mem_w), .addr(addr), .wdata(wdata),
    .rdata(rdata0), .mio_ready(ready0), .ram_addr(ram_addr0), .ram_we(ram_we0),
    .ram_din(ram_din0), .ram_dout(ram_dout0), .led(led0), .sw(sw), .irq(irq0), .bus_err(berr0)
  );

  mio_bus_ctrl #(.RAM_AW(10), .WAIT_STATES(3), .LED_W(8), .SW_W(16)) dut3 (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .mem_w(mem_w), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .mio_ready(ready3), .ram_addr(ram_addr3), .ram_we(ram_we3),
    .ram_din(ram_din3), .ram_dout(ram_dout3), .led(led3), .sw(sw), .irq(irq3), .bus_err(berr3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM models, one per controller.
  always @(posedge clk) begin
    if (ram_we0) mem0[ram_addr0] <= ram_din0;
    ram_dout0 <= mem0[ram_addr0];
    if (ram_we3) mem3[ram_addr3] <= ram_din3;
    ram_dout3 <= mem3[ram_addr3];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void mon_check(input string tag, input exp_t e, input logic [31:0] rd);
    chk({tag, " ready cycle"}, 32'(cyc), 32'(e.cyc));
    if (e.chk) chk({tag, " rdata"}, rd, e.rdata);
  endfunction

  // Monitor: RAM address stability while pending, ram_we tally, completion scoreboard.
  always @(negedge clk) begin
    if (ram_we0) begin we_cnt0++; we_addr0 = ram_addr0; end
    if (ram_we3) begin we_cnt3++; we_addr3 = ram_addr3; end
    if (q0.size() != 0) chk("ws0 ram_addr stable", 32'(ram_addr0), 32'(q0[0].raddr));
    if (q3.size() != 0) chk("ws3 ram_addr stable", 32'(ram_addr3), 32'(q3[0].raddr));
    if (ready0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL ws0 unexpected mio_ready at cycle %0d", cyc);
      end else begin
        mon_check("ws0", q0.pop_front(), rdata0);
      end
    end
    if (ready3) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL ws3 unexpected mio_ready at cycle %0d", cyc);
      end else begin
        mon_check("ws3", q3.pop_front(), rdata3);
      end
    end
  end

  // One bus transaction; cnt_rel makes exp a count base adjusted by cycles since the count write.
  task automatic xact(input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input bit chk_rd, input bit cnt_rel);
    int   acc;
    bit   ram;
    exp_t e;
    @(negedge clk);
    cpu_req = 1'b1; mem_w = we; addr = a; wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    acc = cyc;
    ram = (a < 32'h0000_1000);
    if (we && a == 32'hF000_0000) wr_acc = acc;
    e.rdata = cnt_rel ? exp + 32'(acc - wr_acc - 1) : exp;
    e.chk   = chk_rd;
    e.raddr = a[11:2];
    e.cyc   = acc + (ram ? 2 : 1);
    q0.push_back(e);
    e.cyc   = acc + (ram ? 5 : 1);
    q3.push_back(e);
    for (int i = 0; i < 20; i++) begin
      if (q0.size() == 0 && q3.size() == 0) break;
      @(negedge clk);
    end
    if (q0.size() != 0 || q3.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout addr 0x%08h: pending ws0=%0d ws3=%0d", a, q0.size(), q3.size());
      q0.delete(); q3.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #1;
    chk("reset rdata", rdata0, 32'd0);
    chk("reset mio_ready", 32'(ready0), 32'd0);
    chk("reset ram_addr", 32'(ram_addr0), 32'd0);
    chk("reset ram_we", 32'(ram_we0), 32'd0);
    chk("reset ram_din", ram_din0, 32'd0);
    chk("reset led", 32'(led0), 32'd0);
    chk("reset irq", 32'(irq0), 32'd0);
    chk("reset bus_err", 32'(berr0), 32'd0);
    chk("reset ws3 mio_ready", 32'(ready3), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // RAM write then read back
    we_cnt0 = 0; we_cnt3 = 0;
    xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    chk("ws0 ram_we cycles", 32'(we_cnt0), 32'd1);
    chk("ws0 ram_we addr", 32'(we_addr0), 32'd4);
    chk("ws3 ram_we cycles", 32'(we_cnt3), 32'd1);
    chk("ws3 ram_we addr", 32'(we_addr3), 32'd4);
    xact(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // GPIO
    sw = 16'h1234;
    xact(1'b1, 32'hE000_0000, 32'h0000_00A5, 32'd0, 1'b0, 1'b0);
    chk("ws0 led", 32'(led0), 32'hA5);
    chk("ws3 led", 32'(led3), 32'hA5);
    xact(1'b0, 32'hE000_0004, 32'd0, 32'h0000_1234, 1'b1, 1'b0);
    xact(1'b0, 32'hE000_0000, 32'd0, 32'h0000_00A5, 1'b1, 1'b0);
    xact(1'b1, 32'hE000_0004, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    chk("sw write no bus_err", 32'(berr0), 32'd0);
    chk("sw write led kept", 32'(led0), 32'hA5);

    // Timer: compare match, clear, wrap
    xact(1'b1, 32'hF000_0004, 32'd20, 32'd0, 1'b0, 1'b0);
    xact(1'b1, 32'hF000_0000, 32'd10, 32'd0, 1'b0, 1'b0);
    xact(1'b0, 32'hF000_0000, 32'd0, 32'd10, 1'b1, 1'b1);
    xact(1'b0, 32'hF000_0004, 32'd0, 32'd20, 1'b1, 1'b0);
    while (cyc < wr_acc + 11) @(negedge clk);
    chk("ws0 irq before match", 32'(irq0), 32'd0);
    chk("ws3 irq before match", 32'(irq3), 32'd0);
    @(negedge clk);
    chk("ws0 irq at match", 32'(irq0), 32'd1);
    chk("ws3 irq at match", 32'(irq3), 32'd1);
    xact(1'b1, 32'hF000_0008, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    chk("ws0 irq cleared", 32'(irq0), 32'd0);
    xact(1'b0, 32'hF000_0008, 32'd0, 32'd0, 1'b1, 1'b0);
    xact(1'b1, 32'hF000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    xact(1'b0, 32'hF000_0000, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);

    // Unmapped access
    xact(1'b0, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("ws0 bus_err set", 32'(berr0), 32'd1);
    chk("ws3 bus_err set", 32'(berr3), 32'd1);
    xact(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("bus_err sticky", 32'(berr0), 32'd1);

    // Reset during a RAM write ACCESS
    @(negedge clk);
    cpu_req = 1'b1; mem_w = 1'b1; addr = 32'h0000_0020; wdata = 32'h0000_0055;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid-reset ram_we", 32'(ram_we0), 32'd0);
    chk("mid-reset ws3 ram_we", 32'(ram_we3), 32'd0);
    chk("mid-reset mio_ready", 32'(ready0), 32'd0);
    chk("mid-reset rdata", rdata0, 32'd0);
    chk("mid-reset led", 32'(led0), 32'd0);
    chk("mid-reset bus_err", 32'(berr0), 32'd0);
    chk("mid-reset irq", 32'(irq0), 32'd0);
    chk("mid-reset ram_addr", 32'(ram_addr0), 32'd0);
    chk("mid-reset ram_din", ram_din0, 32'd0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    xact(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
Memory/I-O bus controller directly downstream of the multi-cycle CPU's memory port. It consumes the CPU request (CPU_MIO, mem_w, Addr_out, Data_out), decodes the address, and routes the access to one of three targets: a synchronous block RAM, a GPIO register pair, or a 32-bit timer. It returns read data and a one-cycle MIO_ready pulse, which the CPU control FSM waits on.

Parameters:
RAM_AW, 10, RAM word-address width (4 KiB RAM).
WAIT_STATES, 0, extra stall cycles added to every RAM access (0..15).
LED_W, 8, width of the LED output register.
SW_W, 16, width of the switch input.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset (reset=0 resets all state).
cpu_req  in  1  request strobe (CPU_MIO); sampled only in IDLE.
mem_w  in  1  1 = write, 0 = read; sampled with cpu_req.
addr  in  32  byte address; bits [1:0] ignored (word access only).
wdata  in  32  write data; sampled with cpu_req.
rdata  out  32  read data; registered, valid while mio_ready=1, held until the next completion.
mio_ready  out  1  registered one-cycle completion pulse.
ram_addr  out  RAM_AW  RAM word address = latched addr[RAM_AW+1:2].
ram_we  out  1  RAM write enable.
ram_din  out  32  RAM write data (latched wdata).
ram_dout  in  32  RAM read data; synchronous RAM, valid 1 cycle after the address.
led  out  LED_W  LED register.
sw  in  SW_W  switch inputs, already synchronised upstream.
irq  out  1  sticky timer-match interrupt.
bus_err  out  1  sticky unmapped-access flag.

Behaviour:
- Reset values: rdata=0, mio_ready=0, ram_addr=0, ram_we=0, ram_din=0, led=0, irq=0, bus_err=0, timer count=0, compare=0xFFFF_FFFF, state=IDLE.
- Address map:
  - RAM: addr[31:RAM_AW+2]==0.
  - 0xE000_0000: LED, R/W; reads zero-extended.
  - 0xE000_0004: SW, read-only; writes ignored, no error.
  - 0xF000_0000: timer count, R/W.
  - 0xF000_0004: compare, R/W.
  - 0xF000_0008: write any value to clear irq; reads 0.
  - Anything else is unmapped.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: when cpu_req=1, latch addr, wdata and mem_w, and load wait_cnt. The next state is ACCESS.
  - ACCESS, RAM target: lasts 2+WAIT_STATES cycles. ram_we=mem_w during the first ACCESS cycle only. ram_addr and ram_din stay stable for the whole ACCESS period.
  - ACCESS, I/O or unmapped target: lasts exactly 1 cycle.
  - At the edge ending the last ACCESS cycle: rdata is loaded with the selected read data (RAM: ram_dout), mio_ready<=1, and the I/O write takes effect.
  - DONE: mio_ready=1 for exactly one cycle; the next state is IDLE unconditionally.
- Latency, accept edge E0, WAIT_STATES=0:
  - RAM: mio_ready is high between E2 and E3.
  - I/O: mio_ready is high between E1 and E2.
- cpu_req still high in IDLE after DONE starts a new transaction; the CPU must drop it or advance.
- Writes leave rdata unchanged.
- Unmapped access: the write is dropped, rdata<=0, bus_err<=1 (sticky until reset), with I/O timing.
- Timer:
  - count increments every cycle and wraps 0xFFFF_FFFF -> 0.
  - In the cycle a count write completes, count<=wdata (no increment).
  - irq sets when count==compare. Set has priority over a simultaneous clear.
- Reset mid-transaction: the FSM goes immediately to IDLE, ram_we=0 and mio_ready=0; the transaction is lost.

Decomposition:
- Package mio_pkg holds:
  - address constants (LED_ADDR, SW_ADDR, TMR_CNT, TMR_CMP, TMR_CLR);
  - the state enum {IDLE, ACCESS, DONE};
  - a target enum {T_RAM, T_GPIO, T_TMR, T_ERR}.
- One sub-module, mio_timer, contains count, compare and irq, with a write-select/wdata interface and a read mux.

Test Plan:
1. RAM write 0xDEADBEEF at addr 0x0000_0010, then read it back (WAIT_STATES=0) -> ram_we is high for 1 cycle with ram_addr=4; the read returns rdata=0xDEADBEEF with mio_ready 2 cycles after the accept edge.
2. Rerun case 1 with WAIT_STATES=3 -> mio_ready arrives 5 cycles after the accept edge, is exactly 1 cycle wide, and ram_addr is stable throughout.
3. Write 0xA5 to 0xE000_0000; read 0xE000_0004 with sw=0x1234 -> led=0xA5, rdata=0x0000_1234, I/O latency 1 cycle.
4. Write compare=20 and count=10; wait -> irq rises when count reaches 20; a write to 0xF000_0008 clears it; count=0xFFFF_FFFF wraps to 0.
5. Read 0x8000_0000 -> rdata=0, bus_err=1, mio_ready still pulses; bus_err stays 1 after further valid accesses.
6. Assert reset low during RAM ACCESS -> mio_ready never pulses, ram_we=0, all outputs at reset values; a new request after reset is serviced normally.
